// File: rtl/seqmul_rr_scheduler_if.sv
// Request/response channel bundle between client blocks and the shared multiplier scheduler.
// Requester i owns bit i of req_valid/req_ready and lanes [16i+15:16i] of req_a/req_b.
interface seqmul_rr_scheduler_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [16*NUM_REQ-1:0] req_a;
    logic [16*NUM_REQ-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [31:0]           rsp_product;
    logic                  rsp_error;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_product, rsp_error
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_product, rsp_error
    );
endinterface

// File: rtl/seqmul_rr_scheduler.sv
// Round-robin scheduler sharing one sequential 16x16 multiplier core among NUM_REQ clients,
// with zero-operand short-circuit and a completion watchdog.
module seqmul_rr_scheduler #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    seqmul_rr_scheduler_if.slave bus,
    output logic                 mul_start,
    output logic [15:0]          mul_multiplicand,
    output logic [15:0]          mul_multiplier,
    input  logic                 mul_done,
    input  logic [31:0]          mul_product,
    output logic                 busy,
    output logic                 err_sticky
);
    localparam int unsigned SumW = ID_W + 1;
    localparam int unsigned WdW  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e          state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [15:0]     a_q, a_d, b_q, b_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [31:0]     product_q, product_d;
    logic            rsp_error_q, rsp_error_d;
    logic [WdW-1:0]  wdog_q, wdog_d;
    logic            err_sticky_q, err_sticky_d;

    logic [ID_W-1:0] winner;
    logic            found;
    logic [SumW-1:0] cand_sum;
    logic [ID_W-1:0] cand;
    logic [15:0]     sel_a, sel_b;
    logic            fire;

    // Scan from the highest offset down so the lowest offset from rr_ptr ends up the winner.
    always_comb begin
        winner   = '0;
        found    = 1'b0;
        cand_sum = '0;
        cand     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand_sum = {1'b0, rr_ptr_q} + SumW'(k);
            if (cand_sum >= SumW'(NUM_REQ)) begin
                cand_sum = cand_sum - SumW'(NUM_REQ);
            end
            cand = cand_sum[ID_W-1:0];
            if (bus.req_valid[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == ID_W'(i)) begin
                sel_a = bus.req_a[16*i +: 16];
                sel_b = bus.req_b[16*i +: 16];
            end
        end
    end

    assign fire = (state_q == StIdle) && found && !reset;

    always_comb begin
        bus.req_ready = '0;
        if (fire) begin
            bus.req_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        product_d    = product_q;
        rsp_error_d  = rsp_error_q;
        wdog_d       = wdog_q;
        err_sticky_d = err_sticky_q;
        unique case (state_q)
            StIdle: begin
                if (fire) begin
                    a_d         = sel_a;
                    b_d         = sel_b;
                    id_d        = winner;
                    product_d   = '0;
                    rsp_error_d = 1'b0;
                    rr_ptr_d    = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
                    state_d     = (sel_a == '0 || sel_b == '0) ? StResp : StIssue;
                end
            end
            StIssue: begin
                wdog_d  = '0;
                state_d = StWait;
            end
            StWait: begin
                // A done pulse on the last watchdog cycle still counts as a good result.
                if (mul_done) begin
                    product_d   = mul_product;
                    rsp_error_d = 1'b0;
                    state_d     = StResp;
                end else if (wdog_q == WdW'(TIMEOUT - 1)) begin
                    product_d    = '0;
                    rsp_error_d  = 1'b1;
                    err_sticky_d = 1'b1;
                    state_d      = StResp;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            rr_ptr_q     <= '0;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= '0;
            product_q    <= '0;
            rsp_error_q  <= 1'b0;
            wdog_q       <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            product_q    <= product_d;
            rsp_error_q  <= rsp_error_d;
            wdog_q       <= wdog_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign mul_start        = (state_q == StIssue);
    assign mul_multiplicand = a_q;
    assign mul_multiplier   = b_q;
    assign busy             = (state_q != StIdle);
    assign err_sticky       = err_sticky_q;
    assign bus.rsp_valid    = (state_q == StResp);
    assign bus.rsp_id       = id_q;
    assign bus.rsp_product  = product_q;
    assign bus.rsp_error    = rsp_error_q;
endmodule

// File: tb/tb_seqmul_rr_scheduler.sv
// Directed bench for seqmul_rr_scheduler; the bench itself plays the multiplier core.
module tb_seqmul_rr_scheduler;
    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned ID_W    = 2;
    localparam int unsigned TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        mul_start;
    logic [15:0] mul_multiplicand;
    logic [15:0] mul_multiplier;
    logic        mul_done;
    logic [31:0] mul_product;
    logic        busy;
    logic        err_sticky;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    seqmul_rr_scheduler_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    seqmul_rr_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
        .clk              (clk),
        .reset            (reset),
        .bus              (bus),
        .mul_start        (mul_start),
        .mul_multiplicand (mul_multiplicand),
        .mul_multiplier   (mul_multiplier),
        .mul_done         (mul_done),
        .mul_product      (mul_product),
        .busy             (busy),
        .err_sticky       (err_sticky)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a lone request, check its grant, and leave the bench one cycle after handshake.
    task automatic send(input int idx, input logic [15:0] a, input logic [15:0] b);
        logic [NUM_REQ-1:0] exp_ready;
        exp_ready      = '0;
        exp_ready[idx] = 1'b1;
        bus.req_valid  = exp_ready;
        bus.req_a[16*idx +: 16] = a;
        bus.req_b[16*idx +: 16] = b;
        #1;
        check("grant", 64'(bus.req_ready), 64'(exp_ready));
        tick();
        bus.req_valid = '0;
        #1;
    endtask

    // Called in the ISSUE cycle; spends 'cycles' cycles in WAIT, then pulses done.
    task automatic core_run(input int cycles, input logic [31:0] prod);
        int starts = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (mul_start) starts++;
        end
        mul_done    = 1'b1;
        mul_product = prod;
        tick();
        mul_done    = 1'b0;
        mul_product = '0;
        #1;
        check("single_start", 64'(starts), 64'd0);
    endtask

    task automatic accept();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        #1;
    endtask

    initial begin
        logic [1:0] rr_order [5];
        rr_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        reset         = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        mul_done      = 1'b0;
        mul_product   = '0;
        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_start", 64'(mul_start), 64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_sticky", 64'(err_sticky), 64'd0);
        check("rst_ready", 64'(bus.req_ready), 64'd0);
        check("rst_mcand", 64'(mul_multiplicand), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;

        // Stray done while idle must not create a response.
        mul_done    = 1'b1;
        mul_product = 32'hDEAD;
        tick();
        mul_done    = 1'b0;
        mul_product = '0;
        #1;
        check("stray_done_rsp", 64'(bus.rsp_valid), 64'd0);
        check("stray_done_busy", 64'(busy), 64'd0);

        // Single request, a=3 b=5.
        send(1, 16'd3, 16'd5);
        check("t1_start", 64'(mul_start), 64'd1);
        check("t1_mcand", 64'(mul_multiplicand), 64'd3);
        check("t1_mplier", 64'(mul_multiplier), 64'd5);
        check("t1_busy", 64'(busy), 64'd1);
        core_run(33, 32'd15);
        check("t1_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        check("t1_rsp_id", 64'(bus.rsp_id), 64'd1);
        check("t1_product", 64'(bus.rsp_product), 64'd15);
        check("t1_error", 64'(bus.rsp_error), 64'd0);
        accept();
        check("t1_rsp_drop", 64'(bus.rsp_valid), 64'd0);
        check("t1_idle", 64'(busy), 64'd0);

        // Round robin from rr_ptr=0 with every requester valid (zero operand keeps it short).
        reset = 1'b1;
        #1;
        reset = 1'b0;
        bus.req_a = '0;
        bus.req_b = {4{16'd1}};
        bus.req_valid = 4'hF;
        for (int g = 0; g < 5; g++) begin
            logic [NUM_REQ-1:0] exp_ready;
            exp_ready = '0;
            exp_ready[rr_order[g]] = 1'b1;
            #1;
            check("rr_grant", 64'(bus.req_ready), 64'(exp_ready));
            tick();
            check("rr_rsp_id", 64'(bus.rsp_id), 64'(rr_order[g]));
            check("rr_ready_resp", 64'(bus.req_ready), 64'd0);
            bus.rsp_ready = 1'b1;
            tick();
            bus.rsp_ready = 1'b0;
            if (g == 4) bus.req_valid = '0;
        end
        #1;

        // Zero shortcut on requester 2.
        send(2, 16'd0, 16'hFFFF);
        check("zero_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        check("zero_no_start", 64'(mul_start), 64'd0);
        check("zero_product", 64'(bus.rsp_product), 64'd0);
        check("zero_rsp_id", 64'(bus.rsp_id), 64'd2);
        accept();

        // Backpressure with the largest product.
        send(0, 16'hFFFF, 16'hFFFF);
        core_run(10, 32'hFFFE0001);
        bus.req_valid = 4'b0010;
        #1;
        for (int c = 0; c < 10; c++) begin
            check("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
            check("bp_product", 64'(bus.rsp_product), 64'hFFFE0001);
            check("bp_rsp_id", 64'(bus.rsp_id), 64'd0);
            check("bp_ready_zero", 64'(bus.req_ready), 64'd0);
            tick();
        end
        bus.rsp_ready = 1'b1;
        #1;
        check("bp_ready_at_accept", 64'(bus.req_ready), 64'd0);
        tick();
        bus.rsp_ready = 1'b0;
        #1;
        check("bp_rsp_drop", 64'(bus.rsp_valid), 64'd0);
        check("bp_ready_after", 64'(bus.req_ready), 64'b0010);
        bus.req_valid = '0;
        tick();
        check("bp_withdrawn_idle", 64'(busy), 64'd0);

        // Watchdog: done never arrives.
        send(3, 16'd2, 16'd7);
        for (int k = 0; k < TIMEOUT; k++) tick();
        check("wd_still_wait", 64'(bus.rsp_valid), 64'd0);
        check("wd_sticky_pre", 64'(err_sticky), 64'd0);
        tick();
        check("wd_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        check("wd_error", 64'(bus.rsp_error), 64'd1);
        check("wd_product", 64'(bus.rsp_product), 64'd0);
        check("wd_rsp_id", 64'(bus.rsp_id), 64'd3);
        check("wd_sticky", 64'(err_sticky), 64'd1);
        accept();

        send(0, 16'd3, 16'd4);
        core_run(5, 32'd12);
        check("post_wd_error", 64'(bus.rsp_error), 64'd0);
        check("post_wd_product", 64'(bus.rsp_product), 64'd12);
        check("post_wd_sticky", 64'(err_sticky), 64'd1);
        accept();

        // Done lands on the final watchdog cycle: result wins.
        send(1, 16'h1234, 16'h0010);
        core_run(TIMEOUT, 32'h00012340);
        check("edge_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        check("edge_error", 64'(bus.rsp_error), 64'd0);
        check("edge_product", 64'(bus.rsp_product), 64'h00012340);
        accept();

        // Reset five cycles after the start pulse.
        send(2, 16'd5, 16'd6);
        repeat (5) tick();
        bus.req_valid = 4'b1000;
        reset = 1'b1;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_start", 64'(mul_start), 64'd0);
        check("mid_rst_rsp", 64'(bus.rsp_valid), 64'd0);
        check("mid_rst_mcand", 64'(mul_multiplicand), 64'd0);
        check("mid_rst_mplier", 64'(mul_multiplier), 64'd0);
        check("mid_rst_sticky", 64'(err_sticky), 64'd0);
        check("mid_rst_ready", 64'(bus.req_ready), 64'd0);
        tick();
        reset = 1'b0;
        bus.req_valid = 4'b1100;
        #1;
        check("mid_rst_ptr0", 64'(bus.req_ready), 64'b0100);
        send(3, 16'd7, 16'd9);
        check("mid_rst_start2", 64'(mul_start), 64'd1);
        core_run(3, 32'd63);
        check("mid_rst_rsp_id", 64'(bus.rsp_id), 64'd3);
        check("mid_rst_product", 64'(bus.rsp_product), 64'd63);
        check("mid_rst_error", 64'(bus.rsp_error), 64'd0);
        accept();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
